// File: rtl/rr_burst_if.sv
// Bundle between the requester lanes, the round-robin burst arbiter and its
// downstream consumer.
//   req_vld  : per-lane request valid
//   req_addr : per-lane address, lane i at [i*ADDR_W +: ADDR_W]
//   req_rdy  : per-lane beat accepted (one-hot or zero)
//   out_vld  : downstream beat valid
//   out_addr : downstream beat address
//   out_id   : owning lane index
//   out_last : final beat of the burst
//   out_rdy  : downstream ready
//   busy     : arbiter currently holds a burst
// Modport master is the arbiter side; modport slave is the lane/consumer side.
interface rr_burst_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_rdy;
    logic                      out_vld;
    logic [ADDR_W-1:0]         out_addr;
    logic [ID_W-1:0]           out_id;
    logic                      out_last;
    logic                      out_rdy;
    logic                      busy;

    modport master (
        input  req_vld, req_addr, out_rdy,
        output req_rdy, out_vld, out_addr, out_id, out_last, busy
    );

    modport slave (
        output req_vld, req_addr, out_rdy,
        input  req_rdy, out_vld, out_addr, out_id, out_last, busy
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter. One of NUM_REQ lanes is granted in IDLE (one
// cycle arbitration latency) and then owns the single output port for up to
// BURST_LEN beats. The burst ends on the accepted last beat or as soon as the
// owner drops its valid; the round-robin pointer then moves past the owner.
// Ports:
//   clk : clock
//   rst : synchronous reset, active-high; also blanks acceptance in its cycle
//   bus : rr_burst_if.master (lane requests in, downstream beats out)
module rr_burst_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int CNT_WIDTH = 4,
    parameter int BURST_LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_burst_if.master     bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 state_r;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [ID_W-1:0]        owner_r;
    logic [CNT_WIDTH-1:0]   beat_cnt_r;

    logic [ID_W-1:0]        pick_s;
    logic                   any_vld_s;
    logic                   owner_vld_s;
    logic [ADDR_W-1:0]      owner_addr_s;
    logic                   last_beat_s;
    logic                   beat_s;
    logic                   out_vld_s;
    logic [ADDR_W-1:0]      out_addr_s;
    logic [ID_W-1:0]        out_id_s;
    logic                   out_last_s;
    logic [NUM_REQ-1:0]     req_rdy_s;

    // Lane following the given one, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] next_lane(input logic [ID_W-1:0] lane);
        if (int'(lane) >= NUM_REQ - 1) begin
            next_lane = '0;
        end else begin
            next_lane = lane + ID_W'(1);
        end
    endfunction

    // Round-robin pick: scan from rr_ptr upward; scanning in reverse order
    // lets the lowest offset from rr_ptr win without an early exit.
    always_comb begin
        int base;
        int idx;
        pick_s    = '0;
        any_vld_s = 1'b0;
        base      = 0;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            base      = int'(rr_ptr_r) + i;
            idx       = (base >= NUM_REQ) ? (base - NUM_REQ) : base;
            pick_s    = bus.req_vld[idx] ? ID_W'(idx) : pick_s;
            any_vld_s = any_vld_s | bus.req_vld[idx];
        end
    end

    assign owner_vld_s  = bus.req_vld[owner_r];
    assign owner_addr_s = bus.req_addr[owner_r*ADDR_W +: ADDR_W];
    assign last_beat_s  = (beat_cnt_r == CNT_WIDTH'(BURST_LEN - 1));

    // Output port: only the locked owner is forwarded, and nothing is offered
    // while reset is asserted so an in-flight beat cannot be accepted.
    always_comb begin
        out_vld_s  = 1'b0;
        out_addr_s = '0;
        out_id_s   = '0;
        out_last_s = 1'b0;
        req_rdy_s  = '0;
        if ((state_r == ST_BURST) && !rst) begin
            out_vld_s          = owner_vld_s;
            out_addr_s         = owner_addr_s;
            out_id_s           = owner_r;
            out_last_s         = owner_vld_s & last_beat_s;
            req_rdy_s[owner_r] = bus.out_rdy & owner_vld_s;
        end else begin
            out_vld_s  = 1'b0;
            out_addr_s = '0;
            out_id_s   = '0;
            out_last_s = 1'b0;
            req_rdy_s  = '0;
        end
    end

    assign beat_s = out_vld_s & bus.out_rdy;

    // Arbitration FSM: grant in IDLE, count accepted beats in BURST, release
    // on the accepted last beat or when the owner withdraws its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_vld_s) begin
                        owner_r    <= pick_s;
                        beat_cnt_r <= '0;
                        state_r    <= ST_BURST;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!owner_vld_s || (beat_s && last_beat_s)) begin
                        state_r    <= ST_IDLE;
                        rr_ptr_r   <= next_lane(owner_r);
                        beat_cnt_r <= '0;
                    end else if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rr_ptr_r   <= '0;
                    owner_r    <= '0;
                    beat_cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.out_vld  = out_vld_s;
    assign bus.out_addr = out_addr_s;
    assign bus.out_id   = out_id_s;
    assign bus.out_last = out_last_s;
    assign bus.req_rdy  = req_rdy_s;
    assign bus.busy     = (state_r == ST_BURST);
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scenario bench for rr_burst_arbiter: per-cycle checks in each task plus a
// scoreboard of expected beats consumed by a monitor on accepted beats.
module tb_rr_burst_arbiter;
    localparam int NUM_REQ   = 2;
    localparam int ADDR_W    = 32;
    localparam int CNT_WIDTH = 4;
    localparam int BURST_LEN = 8;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'hA5A5_0001;
    localparam logic [31:0] A2 = 32'h0000_0055;
    localparam logic [31:0] A3 = 32'hDEAD_0300;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] addr;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rr_burst_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

    rr_burst_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W),
        .CNT_WIDTH(CNT_WIDTH), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Scoreboard monitor: every accepted beat must match the next expected one.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (bus.out_vld && bus.out_rdy) begin
            g = '{id: bus.out_id, addr: bus.out_addr, last: bus.out_last};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_beat got id=%0d addr=%h last=%0d exp none", g.id, g.addr, g.last);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    n_errors++;
                    $display("FAIL sb_beat got id=%0d addr=%h last=%0d exp id=%0d addr=%h last=%0d",
                             g.id, g.addr, g.last, e.id, e.addr, e.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1, input logic rdy);
        bus.req_vld  = vld;
        bus.req_addr = {a1, a0};
        bus.out_rdy  = rdy;
    endtask

    task automatic push_burst(input logic [0:0] id, input logic [31:0] addr, input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{id: id, addr: addr, last: (full && (i == n - 1))});
        end
    endtask

    task automatic test_reset();
        logic [37:0] got;
        rst = 1'b1;
        drive(2'b11, A0, A1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            cyc();
            smp();
            got = {bus.busy, bus.out_vld, bus.req_rdy, bus.out_last, bus.out_id, bus.out_addr};
            n_checks++;
            if (got !== 38'd0) begin
                n_errors++;
                $display("FAIL reset_outputs got=%h exp=0", got);
            end
        end
    endtask

    task automatic test_single_burst();
        logic [5:0] got;
        logic [5:0] exp;
        cyc();
        rst = 1'b0;
        drive(2'b01, A0, A1, 1'b1);
        push_burst(1'b0, A0, 8, 1'b1);
        smp();
        n_checks++;
        if ({bus.busy, bus.out_vld} !== 2'b00) begin
            n_errors++;
            $display("FAIL arb_latency got busy/vld=%b exp=00", {bus.busy, bus.out_vld});
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            smp();
            got = {bus.busy, bus.out_vld, bus.out_id, bus.out_last, bus.req_rdy};
            exp = {1'b1, 1'b1, 1'b0, (k == 8), 2'b01};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL burst0_beat k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        cyc();
        drive(2'b00, A0, A1, 1'b1);
        smp();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL burst0_release got busy=%b exp=0", bus.busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL burst0_beats_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_alternate();
        logic [3:0] got;
        logic [3:0] exp;
        logic [0:0] id;
        cyc();
        drive(2'b11, A0, A1, 1'b1);
        // Pointer is 1 after the lane-0 burst, so lane 1 wins first.
        for (int b = 0; b < 4; b++) begin
            id = (b % 2 == 0) ? 1'b1 : 1'b0;
            push_burst(id, id ? A1 : A0, 8, 1'b1);
        end
        for (int b = 0; b < 4; b++) begin
            id = (b % 2 == 0) ? 1'b1 : 1'b0;
            if (b != 0) cyc();
            smp();
            n_checks++;
            if ({bus.busy, bus.out_vld} !== 2'b00) begin
                n_errors++;
                $display("FAIL alt_idle_gap b=%0d got=%b exp=00", b, {bus.busy, bus.out_vld});
            end
            for (int k = 1; k <= 8; k++) begin
                cyc();
                smp();
                got = {bus.busy, bus.out_vld, bus.out_id, bus.out_last};
                exp = {1'b1, 1'b1, id, (k == 8)};
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL alt_beat b=%0d k=%0d got=%b exp=%b", b, k, got, exp);
                end
            end
        end
        cyc();
        drive(2'b00, A0, A1, 1'b1);
        smp();
        n_checks++;
        if ((bus.busy !== 1'b0) || (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL alt_end got busy=%b left=%0d exp busy=0 left=0", bus.busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] got;
        logic [5:0] exp;
        logic       rdy;
        int         acc;
        cyc();
        drive(2'b11, A0, A1, 1'b0);
        push_burst(1'b1, A1, 8, 1'b1);
        smp();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_idle got busy=%b exp=0", bus.busy);
        end
        acc = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            rdy = (k % 2 == 1);
            bus.out_rdy = rdy;
            smp();
            got = {bus.busy, bus.out_vld, bus.out_id, bus.out_last, bus.req_rdy};
            exp = {1'b1, 1'b1, 1'b1, (acc == 7), (rdy ? 2'b10 : 2'b00)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL bp_beat k=%0d got=%b exp=%b", k, got, exp);
            end
            if (rdy) acc++;
        end
        cyc();
        drive(2'b00, A0, A1, 1'b1);
        smp();
        n_checks++;
        if ((bus.busy !== 1'b0) || (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL bp_end got busy=%b left=%0d exp busy=0 left=0", bus.busy, exp_q.size());
        end
    endtask

    task automatic test_drop();
        logic [3:0] got;
        cyc();
        drive(2'b01, A2, A1, 1'b1);
        push_burst(1'b0, A2, 3, 1'b0);
        smp();
        for (int k = 1; k <= 3; k++) begin
            cyc();
            smp();
            got = {bus.busy, bus.out_vld, bus.out_id, bus.out_last};
            n_checks++;
            if (got !== 4'b1100) begin
                n_errors++;
                $display("FAIL drop_beat k=%0d got=%b exp=1100", k, got);
            end
        end
        cyc();
        drive(2'b00, A2, A1, 1'b1);
        smp();
        got = {bus.busy, bus.out_vld, bus.req_rdy};
        n_checks++;
        if (got !== 4'b1000) begin
            n_errors++;
            $display("FAIL drop_no_beat got=%b exp=1000", got);
        end
        cyc();
        drive(2'b11, A2, A1, 1'b1);
        push_burst(1'b1, A1, 1, 1'b0);
        smp();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL drop_release got busy=%b exp=0", bus.busy);
        end
        cyc();
        smp();
        n_checks++;
        if ({bus.out_vld, bus.out_id} !== 2'b11) begin
            n_errors++;
            $display("FAIL drop_rr_ptr got vld/id=%b exp=11", {bus.out_vld, bus.out_id});
        end
        cyc();
        drive(2'b00, A2, A1, 1'b1);
        smp();
        cyc();
        smp();
        n_checks++;
        if ((bus.busy !== 1'b0) || (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL drop_end got busy=%b left=%0d exp busy=0 left=0", bus.busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] got;
        logic [3:0] exp;
        // Short lane-0 burst ended by a drop leaves the pointer at 1.
        cyc();
        drive(2'b01, A3, A1, 1'b1);
        push_burst(1'b0, A3, 1, 1'b0);
        smp();
        cyc();
        smp();
        cyc();
        drive(2'b00, A3, A1, 1'b1);
        smp();
        cyc();
        drive(2'b01, A3, A1, 1'b1);
        push_burst(1'b0, A3, 4, 1'b0);
        smp();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            smp();
            got = {bus.busy, bus.out_vld, bus.out_id, bus.out_last};
            n_checks++;
            if (got !== 4'b1100) begin
                n_errors++;
                $display("FAIL rst_pre_beat k=%0d got=%b exp=1100", k, got);
            end
        end
        cyc();
        rst = 1'b1;
        smp();
        n_checks++;
        if ({bus.out_vld, bus.req_rdy} !== 3'b000) begin
            n_errors++;
            $display("FAIL rst_blocks_beat got=%b exp=000", {bus.out_vld, bus.req_rdy});
        end
        cyc();
        rst = 1'b0;
        drive(2'b11, A3, A1, 1'b1);
        push_burst(1'b0, A3, 8, 1'b1);
        smp();
        n_checks++;
        if ({bus.busy, bus.out_vld} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_abort got busy/vld=%b exp=00", {bus.busy, bus.out_vld});
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            smp();
            got = {bus.busy, bus.out_vld, bus.out_id, bus.out_last};
            exp = {1'b1, 1'b1, 1'b0, (k == 8)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL rst_post_beat k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        cyc();
        drive(2'b00, A3, A1, 1'b1);
        smp();
        n_checks++;
        if ((bus.busy !== 1'b0) || (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL rst_end got busy=%b left=%0d exp busy=0 left=0", bus.busy, exp_q.size());
        end
    endtask

    initial begin
        drive(2'b00, A0, A1, 1'b0);
        test_reset();
        test_single_burst();
        test_alternate();
        test_backpressure();
        test_drop();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
